// File: rtl/aes_stream_ctrl_if.sv
// aes_stream_ctrl_if
//   Bundles the stream-side and core-side signals of aes_stream_ctrl.
//   slave  : the controller view (receives input words, drives output words
//            and the AES core operands/reset).
//   master : the environment view (upstream source, downstream sink, and
//            the AES core itself).
//   Signals:
//     in_valid/in_ready/in_data/in_is_key   upstream 32-bit key/plaintext words
//     out_valid/out_ready/out_data/out_last downstream 32-bit ciphertext words
//     busy, timeout_err                     status
//     core_plaintext/core_key/core_rst_n    operands and reset to the AES core
//     core_done/core_ciphertext             result from the AES core
`timescale 1ns/1ps
interface aes_stream_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_is_key;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         timeout_err;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic         core_rst_n;
  logic         core_done;
  logic [127:0] core_ciphertext;

  modport slave (
    input  in_valid, in_data, in_is_key, out_ready, core_done, core_ciphertext,
    output in_ready, out_valid, out_data, out_last, busy, timeout_err,
           core_plaintext, core_key, core_rst_n
  );

  modport master (
    output in_valid, in_data, in_is_key, out_ready, core_done, core_ciphertext,
    input  in_ready, out_valid, out_data, out_last, busy, timeout_err,
           core_plaintext, core_key, core_rst_n
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
//   Stream controller around an iterative AES-128 core. Collects 32-bit key
//   and plaintext words MSB-first, starts the core for exactly one block by
//   owning its reset, captures the ciphertext on done and drains it as four
//   32-bit words MSB-first.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : aes_stream_ctrl_if.slave (stream handshakes, status, core link)
//   Parameters:
//     TIMEOUT_CYCLES : RUN-cycle limit for the watchdog (10-bit counter)
//   Configuration macro:
//     AES_STREAM_TIMEOUT_EN : when defined, a watchdog aborts a RUN that sees
//     no core_done within TIMEOUT_CYCLES and sets sticky timeout_err; when
//     undefined, RUN waits for core_done indefinitely and timeout_err is 0.
`timescale 1ns/1ps
module aes_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input logic              clk,
  input logic              rst,
  aes_stream_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t       state_q,   state_d;
  logic [127:0] key_q,     key_d;
  logic [127:0] pt_q,      pt_d;
  logic [127:0] ct_q,      ct_d;
  logic [2:0]   key_cnt_q, key_cnt_d;
  logic [2:0]   pt_cnt_q,  pt_cnt_d;
  logic         key_ok_q,  key_ok_d;
  logic [1:0]   out_cnt_q, out_cnt_d;
`ifdef AES_STREAM_TIMEOUT_EN
  logic [9:0]   wd_cnt_q,  wd_cnt_d;
  logic         timeout_err_q, timeout_err_d;
`endif

  logic in_ready;
  logic in_fire;
  logic out_fire;

  // in_ready looks at in_is_key (which word type is offered) but never at
  // in_valid; rst gates it so nothing is accepted during a reset cycle.
  assign in_ready = !rst && (state_q == S_LOAD) &&
                    (bus.in_is_key || (pt_cnt_q != 3'd4));
  assign in_fire  = in_ready && bus.in_valid;
  assign out_fire = (state_q == S_DRAIN) && bus.out_ready;

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == S_DRAIN);
  assign bus.out_last       = (state_q == S_DRAIN) && (out_cnt_q == 2'd3);
  // Word 0 sits in [127:96]; {~cnt, 5'd0} is the bit offset (3-cnt)*32.
  assign bus.out_data       = ct_q[{~out_cnt_q, 5'd0} +: 32];
  assign bus.busy           = (state_q != S_LOAD);
  assign bus.core_rst_n     = (state_q == S_RUN);
  assign bus.core_plaintext = pt_q;
  assign bus.core_key       = key_q;
`ifdef AES_STREAM_TIMEOUT_EN
  assign bus.timeout_err    = timeout_err_q;
`else
  assign bus.timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    key_cnt_d = key_cnt_q;
    pt_cnt_d  = pt_cnt_q;
    key_ok_d  = key_ok_q;
    out_cnt_d = out_cnt_q;
`ifdef AES_STREAM_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      S_LOAD: begin
        if (in_fire && bus.in_is_key) begin
          if (key_ok_q) begin
            // A key word after a complete key starts a fresh key.
            key_d[127:96] = bus.in_data;
            key_cnt_d     = 3'd1;
            key_ok_d      = 1'b0;
          end else begin
            key_d[{~key_cnt_q[1:0], 5'd0} +: 32] = bus.in_data;
            key_cnt_d = key_cnt_q + 3'd1;
            key_ok_d  = (key_cnt_q == 3'd3);
          end
        end else if (in_fire) begin
          pt_d[{~pt_cnt_q[1:0], 5'd0} +: 32] = bus.in_data;
          pt_cnt_d = pt_cnt_q + 3'd1;
        end
        if ((pt_cnt_q == 3'd4) && key_ok_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
`ifdef AES_STREAM_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
        state_d = S_RUN;
      end

      S_RUN: begin
`ifdef AES_STREAM_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q + 10'd1;
`endif
        if (bus.core_done) begin
          ct_d      = bus.core_ciphertext;
          out_cnt_d = '0;
          state_d   = S_DRAIN;
        end
`ifdef AES_STREAM_TIMEOUT_EN
        else if (wd_cnt_q == 10'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          pt_cnt_d      = '0;
          state_d       = S_LOAD;
        end
`endif
      end

      S_DRAIN: begin
        if (out_fire) begin
          if (out_cnt_q == 2'd3) begin
            pt_cnt_d = '0;
            state_d  = S_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      key_q     <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
      key_cnt_q <= '0;
      pt_cnt_q  <= '0;
      key_ok_q  <= 1'b0;
      out_cnt_q <= '0;
`ifdef AES_STREAM_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      key_cnt_q <= key_cnt_d;
      pt_cnt_q  <= pt_cnt_d;
      key_ok_q  <= key_ok_d;
      out_cnt_q <= out_cnt_d;
`ifdef AES_STREAM_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule
